// File: rtl/fpu_arbiter.sv
// Round-robin front end that shares one fixed-latency FPU between NUM_REQ requesters.
// Tags follow each operation through the FPU pipeline so the result reaches the requester that issued it.
module fpu_arbiter #(
    parameter int BIT_SIZE = 15,
    parameter int NUM_REQ  = 4,
    parameter int LATENCY  = 4,
    parameter int IDX_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      cfg_rmode,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [3*NUM_REQ-1:0]            req_op,
    input  logic [(BIT_SIZE+1)*NUM_REQ-1:0] req_opa,
    input  logic [(BIT_SIZE+1)*NUM_REQ-1:0] req_opb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [(BIT_SIZE+1)*NUM_REQ-1:0] rsp_data,
    output logic [8*NUM_REQ-1:0]            rsp_flags,
    output logic [1:0]                      fpu_rmode,
    output logic [2:0]                      fpu_op,
    output logic [BIT_SIZE:0]               fpu_opa,
    output logic [BIT_SIZE:0]               fpu_opb,
    input  logic [BIT_SIZE:0]               fpu_out,
    input  logic [7:0]                      fpu_flags,
    output logic                            busy
);
    localparam int W = BIT_SIZE + 1;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_INFL = 2'd1,
        SLOT_DONE = 2'd2
    } slot_e;

    slot_e                        slot_q [NUM_REQ];
    slot_e                        slot_d [NUM_REQ];
    logic [IDX_W-1:0]             last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]           eligible_s, grant_s;
    logic [IDX_W-1:0]             grant_idx_s, cand_idx_s;
    logic                         grant_any_s, hit_s, issue_s;
    logic [LATENCY-1:0]           tag_v_q, tag_v_d;
    logic [LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic                         retire_s;
    logic [IDX_W-1:0]             retire_idx_s;
    logic [2:0]                   op_sel_s, fpu_op_q, fpu_op_d;
    logic [W-1:0]                 opa_sel_s, opb_sel_s;
    logic [W-1:0]                 fpu_opa_q, fpu_opa_d, fpu_opb_q, fpu_opb_d;
    logic [1:0]                   fpu_rmode_q, fpu_rmode_d;
    logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]                 rsp_data_q [NUM_REQ];
    logic [7:0]                   rsp_flags_q [NUM_REQ];
    logic                         busy_q;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        eligible_s  = '0;
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        cand_idx_s  = '0;
        hit_s       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx_s  = IDX_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
            hit_s       = !grant_any_s && eligible_s[cand_idx_s];
            grant_s     = grant_s | (NUM_REQ'(hit_s) << cand_idx_s);
            grant_idx_s = hit_s ? cand_idx_s : grant_idx_s;
            grant_any_s = grant_any_s | hit_s;
        end
    end

    assign req_ready = rst ? '0 : grant_s;
    assign issue_s   = grant_any_s && !rst;

    // Operand selection from the one-hot grant, tag pipe advance and slot transitions.
    always_comb begin
        op_sel_s  = 3'd0;
        opa_sel_s = '0;
        opb_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_sel_s  = op_sel_s  | ({3{grant_s[i]}} & req_op[3*i +: 3]);
            opa_sel_s = opa_sel_s | ({W{grant_s[i]}} & req_opa[W*i +: W]);
            opb_sel_s = opb_sel_s | ({W{grant_s[i]}} & req_opb[W*i +: W]);
        end
        fpu_op_d    = issue_s ? op_sel_s  : fpu_op_q;
        fpu_opa_d   = issue_s ? opa_sel_s : fpu_opa_q;
        fpu_opb_d   = issue_s ? opb_sel_s : fpu_opb_q;
        fpu_rmode_d = issue_s ? cfg_rmode : fpu_rmode_q;
        last_grant_d = issue_s ? grant_idx_s : last_grant_q;

        tag_v_d      = {tag_v_q[LATENCY-1:0], issue_s};
        tag_idx_d    = {tag_idx_q[LATENCY-1:0], grant_idx_s};
        retire_s     = tag_v_q[LATENCY-1];
        retire_idx_s = tag_idx_q[LATENCY-1];

        // Retire and drain can never target the same slot, so each slot sees at most one event.
        for (int i = 0; i < NUM_REQ; i++) begin
            case (slot_q[i])
                SLOT_IDLE: slot_d[i] = grant_s[i] ? SLOT_INFL : SLOT_IDLE;
                SLOT_INFL: slot_d[i] = (retire_s && (retire_idx_s == IDX_W'(i))) ? SLOT_DONE : SLOT_INFL;
                SLOT_DONE: slot_d[i] = rsp_ready[i] ? SLOT_IDLE : SLOT_DONE;
                default:   slot_d[i] = SLOT_IDLE;
            endcase
            rsp_valid_d[i] = (slot_d[i] == SLOT_DONE);
        end
    end

    // State, FPU input and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i]      <= SLOT_IDLE;
                rsp_data_q[i]  <= '0;
                rsp_flags_q[i] <= 8'h00;
            end
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            tag_v_q      <= '0;
            tag_idx_q    <= '0;
            fpu_op_q     <= 3'd0;
            fpu_opa_q    <= '0;
            fpu_opb_q    <= '0;
            fpu_rmode_q  <= 2'd0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= slot_d[i];
                if (retire_s && (retire_idx_s == IDX_W'(i))) begin
                    rsp_data_q[i]  <= fpu_out;
                    rsp_flags_q[i] <= fpu_flags;
                end
            end
            last_grant_q <= last_grant_d;
            tag_v_q      <= tag_v_d;
            tag_idx_q    <= tag_idx_d;
            fpu_op_q     <= fpu_op_d;
            fpu_opa_q    <= fpu_opa_d;
            fpu_opb_q    <= fpu_opb_d;
            fpu_rmode_q  <= fpu_rmode_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= |tag_v_d;
        end
    end

    // Flatten per-requester response registers onto the packed output buses.
    always_comb begin
        rsp_data  = '0;
        rsp_flags = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data[W*i +: W]  = rsp_data_q[i];
            rsp_flags[8*i +: 8] = rsp_flags_q[i];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_opa   = fpu_opa_q;
    assign fpu_opb   = fpu_opb_q;
    assign fpu_rmode = fpu_rmode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small behavioural FPU of fixed latency.
module tb_fpu_arbiter;
    localparam int BS  = 15;
    localparam int NR  = 4;
    localparam int LAT = 4;
    localparam int IW  = 2;
    localparam int W   = BS + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      cfg_rmode;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3*NR-1:0] req_op;
    logic [W*NR-1:0] req_opa, req_opb, rsp_data;
    logic [8*NR-1:0] rsp_flags;
    logic [1:0]      fpu_rmode;
    logic [2:0]      fpu_op;
    logic [W-1:0]    fpu_opa, fpu_opb, fpu_out;
    logic [7:0]      fpu_flags;
    logic            busy;
    int              checks = 0;
    int              errors = 0;
    logic [23:0]     fpipe [LAT-1];

    always #5 clk = ~clk;

    fpu_arbiter #(.BIT_SIZE(BS), .NUM_REQ(NR), .LATENCY(LAT), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .cfg_rmode(cfg_rmode),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_opa(req_opa), .req_opb(req_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .fpu_rmode(fpu_rmode), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
        .fpu_out(fpu_out), .fpu_flags(fpu_flags), .busy(busy)
    );

    // Known half-precision cases; anything else gets a recognisable sum/xor pattern.
    function automatic logic [23:0] fpu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op == 3'd0 && a == 16'h3C00 && b == 16'h4000) return {8'h00, 16'h4200};
        else if (op == 3'd2 && a == 16'h4000 && b == 16'h4200) return {8'h00, 16'h4600};
        else if (op == 3'd3 && a == 16'h3C00 && b == 16'h0000) return {8'h22, 16'h7C00};
        else return {a[7:0] ^ b[7:0], a + b};
    endfunction

    always @(posedge clk) begin
        fpipe[0] <= fpu_model(fpu_op, fpu_opa, fpu_opb);
        for (int k = 1; k < LAT - 1; k++) fpipe[k] <= fpipe[k-1];
    end
    assign {fpu_flags, fpu_out} = fpipe[LAT-2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] dat(input int i);
        return rsp_data[W*i +: W];
    endfunction

    function automatic logic [7:0] flg(input int i);
        return rsp_flags[8*i +: 8];
    endfunction

    initial begin
        rst = 1'b1; cfg_rmode = 2'b10; req_valid = 4'hF; rsp_ready = 4'h0;
        req_op = '0; req_opa = '0; req_opb = '0;
        step(2);
        chk("rst_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fpu", {fpu_rmode, fpu_op, fpu_opa}, 32'h0);
        chk("rst_data", {31'b0, |rsp_data}, 32'h0);
        chk("rst_flags", {31'b0, |rsp_flags}, 32'h0);
        rst = 1'b0; req_valid = 4'h0;
        step(1);

        // Single add on requester 0
        req_op[2:0] = 3'd0; req_opa[15:0] = 16'h3C00; req_opb[15:0] = 16'h4000; req_valid = 4'b0001;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        step(1);
        req_valid = 4'b0000; #1;
        chk("t1_fpu_opa", fpu_opa, 16'h3C00);
        chk("t1_fpu_opb", fpu_opb, 16'h4000);
        chk("t1_fpu_op", fpu_op, 3'd0);
        chk("t1_rmode", fpu_rmode, 2'b10);
        chk("t1_busy", busy, 1'b1);
        chk("t1_no_rsp_t1", rsp_valid, 4'h0);
        step(3);
        chk("t1_no_rsp_t4", rsp_valid, 4'h0);
        step(1);
        chk("t1_rsp_t5", rsp_valid, 4'b0001);
        chk("t1_data", dat(0), 16'h4200);
        chk("t1_flags", flg(0), 8'h00);
        chk("t1_busy_done", busy, 1'b0);
        step(1);
        chk("t1_rsp_held", rsp_valid, 4'b0001);
        rsp_ready = 4'b0001; #1;
        step(1);
        chk("t1_drained", rsp_valid, 4'h0);
        chk("t1_data_hold", dat(0), 16'h4200);
        rsp_ready = 4'h0;

        // Contention after reset: grants 0,1,2,3 then wrap to 0
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_op[3*i +: 3] = 3'd0;
            req_opa[W*i +: W] = 16'h1000 + 16'(i);
            req_opb[W*i +: W] = 16'h0010;
        end
        rsp_ready = 4'hF; req_valid = 4'hF; #1;
        chk("c_grant0", req_ready, 4'b0001);
        step(1);
        chk("c_grant1", req_ready, 4'b0010);
        chk("c_opa0", fpu_opa, 16'h1000);
        step(1);
        chk("c_grant2", req_ready, 4'b0100);
        chk("c_opa1", fpu_opa, 16'h1001);
        step(1);
        chk("c_grant3", req_ready, 4'b1000);
        step(1);
        chk("c_none", req_ready, 4'b0000);
        step(1);
        chk("c_rsp0", rsp_valid, 4'b0001);
        chk("c_data0", dat(0), 16'h1010);
        chk("c_flags0", flg(0), 8'h10);
        step(1);
        chk("c_rsp1", rsp_valid, 4'b0010);
        chk("c_data1", dat(1), 16'h1011);
        chk("c_wrap", req_ready, 4'b0001);
        step(1);
        req_valid = 4'h0; #1;
        chk("c_rsp2", rsp_valid, 4'b0100);
        chk("c_data2", dat(2), 16'h1012);
        step(1);
        chk("c_rsp3", rsp_valid, 4'b1000);
        chk("c_data3", dat(3), 16'h1013);
        chk("c_flags3", flg(3), 8'h13);
        step(6);
        chk("c_idle_busy", busy, 1'b0);
        chk("c_idle_rsp", rsp_valid, 4'h0);

        // Back-pressure on requester 1 while requester 2 keeps issuing
        rst = 1'b1; step(1); rst = 1'b0;
        req_op[5:3] = 3'd2; req_opa[31:16] = 16'h4000; req_opb[31:16] = 16'h4200;
        req_op[8:6] = 3'd0; req_opa[47:32] = 16'h0002; req_opb[47:32] = 16'h0003;
        rsp_ready = 4'b1101; req_valid = 4'b0110; #1;
        chk("bp_grant1", req_ready, 4'b0010);
        step(1);
        chk("bp_grant2", req_ready, 4'b0100);
        step(1);
        chk("bp_none", req_ready, 4'b0000);
        step(3);
        chk("bp_rsp1", rsp_valid, 4'b0010);
        chk("bp_data1", dat(1), 16'h4600);
        chk("bp_flags1", flg(1), 8'h00);
        step(1);
        chk("bp_rsp12", rsp_valid, 4'b0110);
        chk("bp_data2", dat(2), 16'h0005);
        chk("bp_flags2", flg(2), 8'h01);
        chk("bp_ready_b6", req_ready, 4'b0000);
        step(1);
        chk("bp_req2_again", req_ready, 4'b0100);
        req_valid = 4'b0010; #1;
        step(3);
        chk("bp_r1_blocked", req_ready, 4'b0000);
        chk("bp_rsp1_held", rsp_valid, 4'b0010);
        chk("bp_data1_held", dat(1), 16'h4600);
        rsp_ready = 4'hF; #1;
        chk("bp_drain_same", req_ready, 4'b0000);
        step(1);
        chk("bp_drain_next", req_ready, 4'b0010);
        chk("bp_drained", rsp_valid, 4'h0);
        req_valid = 4'h0;
        step(2);

        // Divide by zero flags on requester 2
        req_op[8:6] = 3'd3; req_opa[47:32] = 16'h3C00; req_opb[47:32] = 16'h0000;
        rsp_ready = 4'b1011; req_valid = 4'b0100; #1;
        chk("f_grant", req_ready, 4'b0100);
        step(1);
        req_valid = 4'h0;
        step(4);
        chk("f_rsp", rsp_valid, 4'b0100);
        chk("f_data", dat(2), 16'h7C00);
        chk("f_flags", flg(2), 8'h22);
        rsp_ready = 4'hF; #1;
        step(1);
        chk("f_drained", rsp_valid, 4'h0);

        // Drain/reissue edge on requester 3
        req_op[11:9] = 3'd0; req_opa[63:48] = 16'h0007; req_opb[63:48] = 16'h0001;
        rsp_ready = 4'b0111; req_valid = 4'b1000; #1;
        chk("d_grant", req_ready, 4'b1000);
        step(5);
        chk("d_rsp", rsp_valid, 4'b1000);
        chk("d_data", dat(3), 16'h0008);
        chk("d_flags", flg(3), 8'h06);
        chk("d_ready_done", req_ready, 4'b0000);
        step(1);
        chk("d_ready_held", req_ready, 4'b0000);
        rsp_ready = 4'hF; #1;
        chk("d_same_cycle", req_ready, 4'b0000);
        step(1);
        chk("d_next_cycle", req_ready, 4'b1000);
        chk("d_rsp_gone", rsp_valid, 4'h0);
        req_valid = 4'h0;
        step(2);

        // Reset mid-flight discards in-flight ops
        req_valid = 4'b0011; #1;
        chk("r_grant0", req_ready, 4'b0001);
        step(1);
        chk("r_grant1", req_ready, 4'b0010);
        step(1);
        req_valid = 4'b0100; rst = 1'b1; #1;
        chk("r_forced", req_ready, 4'b0000);
        chk("r_busy_pre", busy, 1'b1);
        step(1);
        rst = 1'b0; req_valid = 4'h0; #1;
        chk("r_busy_post", busy, 1'b0);
        chk("r_rsp_post", rsp_valid, 4'h0);
        chk("r_fpu_clr", fpu_opa, 16'h0000);
        for (int c = 0; c < 8; c++) begin
            step(1);
            chk("r_no_rsp", rsp_valid, 4'h0);
        end
        req_valid = 4'b0011; #1;
        chk("r_next_grant", req_ready, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
